// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states, mode-0 constants and default sizing
// reused by the slave bench.
package spi_pkg;

    localparam int unsigned SPI_DATA_W  = 8;
    localparam int unsigned SPI_CLK_DIV = 4;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick_c every CLK_DIV enabled cycles,
// counter held at zero while clr is high.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned       CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_c = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d  = '0;
                tick_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one DATA_W-bit word per ss_n frame behind a valid/ready port.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first bit order on mosi and rx_data.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              ss_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned BIT_W = $clog2(DATA_W);

    spi_state_e        state_q,     state_d;
    logic              sck_q,       sck_d;
    logic              ss_n_q,      ss_n_d;
    logic              mosi_q,      mosi_d;
    logic              tx_ready_q,  tx_ready_d;
    logic              rx_valid_q,  rx_valid_d;
    logic [DATA_W-1:0] rx_data_q,   rx_data_d;
    logic [DATA_W-1:0] tx_shift_q,  tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q,  rx_shift_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic              miso_meta_q, miso_meta_d;
    logic              miso_sync_q, miso_sync_d;

    logic              tick_c;
    logic              first_bit_c;
    logic              next_bit_c;
    logic [DATA_W-1:0] tx_shifted_c;
    logic [DATA_W-1:0] rx_shifted_c;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q != IDLE),
        .clr    (state_q == IDLE),
        .tick_c (tick_c)
    );

    // Bit order only changes which end of the shift registers faces the wire.
`ifdef SPI_MASTER_LSB_FIRST_EN
    assign first_bit_c  = tx_data[0];
    assign next_bit_c   = tx_shift_q[1];
    assign tx_shifted_c = tx_shift_q >> 1;
    assign rx_shifted_c = {miso_sync_q, rx_shift_q[DATA_W-1:1]};
`else
    assign first_bit_c  = tx_data[DATA_W-1];
    assign next_bit_c   = tx_shift_q[DATA_W-2];
    assign tx_shifted_c = tx_shift_q << 1;
    assign rx_shifted_c = {rx_shift_q[DATA_W-2:0], miso_sync_q};
`endif

    always_comb begin
        state_d     = state_q;
        sck_d       = sck_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        tx_ready_d  = 1'b0;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        miso_meta_d = miso;
        miso_sync_d = miso_meta_q;

        unique case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                if (tx_valid && tx_ready_q) begin
                    state_d    = LEAD;
                    tx_ready_d = 1'b0;
                    ss_n_d     = 1'b0;
                    mosi_d     = first_bit_c;
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            LEAD: begin
                if (tick_c) begin
                    state_d = SHIFT;
                    sck_d   = ~CPOL;
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    if (sck_q == CPOL) begin
                        sck_d = ~CPOL;
                    end else begin
                        // Falling edge: capture miso and present the next bit.
                        sck_d      = CPOL;
                        rx_shift_d = rx_shifted_c;
                        tx_shift_d = tx_shifted_c;
                        mosi_d     = next_bit_c;
                        if (bit_cnt_q == BIT_W'(DATA_W - 1)) state_d = TRAIL;
                        else bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            TRAIL: begin
                if (tick_c) begin
                    state_d    = GAP;
                    ss_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                end
            end
            GAP: begin
                if (tick_c) begin
                    state_d    = IDLE;
                    tx_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sck_d   = CPOL;
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sck_q       <= CPOL;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_q       <= sck_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            tx_ready_q  <= tx_ready_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_meta_q <= miso_meta_d;
            miso_sync_q <= miso_sync_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sck      = sck_q;
    assign ss_n     = ss_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master against a frame-level SPI model;
// honours SPI_MASTER_LSB_FIRST_EN for the expected bit order.
module tb_spi_master;
    import spi_pkg::*;

    localparam int unsigned DATA_W  = SPI_DATA_W;
    localparam int unsigned CLK_DIV = SPI_CLK_DIV;
    localparam int DW = int'(DATA_W);
    localparam int CD = int'(CLK_DIV);

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              miso_drv = 1'b0;
    logic              loopback = 1'b0;
    logic              tx_ready, rx_valid, sck, ss_n, mosi, miso;
    logic [DATA_W-1:0] rx_data;

    int n_checks = 0;
    int n_pass   = 0;

    assign miso = loopback ? mosi : miso_drv;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .sck      (sck),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Position in the word of the k-th bit on the wire.
    function automatic int wire_pos(input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return k;
`else
        return DW - 1 - k;
`endif
    endfunction

    // Timeline relative to the accept edge; cycle n is sampled after the n-th edge.
    function automatic int rise_cyc(input int k);
        return 1 + CD + 2 * CD * k;
    endfunction
    function automatic int fall_cyc(input int k);
        return rise_cyc(k) + CD;
    endfunction
    function automatic int end_cyc();
        return fall_cyc(DW - 1) + CD;
    endfunction
    function automatic int ready_cyc();
        return end_cyc() + CD;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 300), 32'd1);
    endtask

    // One framed transfer; slave returns sword unless miso is looped back.
    task automatic run_word(input string tag, input logic [DATA_W-1:0] word,
                            input logic [DATA_W-1:0] sword, input logic lb);
        logic [DATA_W-1:0] exp_rx, mosi_seen, got_rx;
        int rises, falls, rise_err, fall_err, win_err, rxv_cnt, rxv_at;
        int first_low, high_at, rdy_at, idle_mosi_err, last_fall;
        logic prev_sck, prev_ss;
        exp_rx = lb ? word : sword;
        mosi_seen = '0; got_rx = '0;
        rises = 0; falls = 0; rise_err = 0; fall_err = 0; win_err = 0;
        rxv_cnt = 0; rxv_at = -1; first_low = -1; high_at = -1; rdy_at = -1;
        idle_mosi_err = 0; last_fall = -1;
        prev_sck = 1'b0; prev_ss = 1'b1;

        wait_ready(tag);
        loopback = lb;
        miso_drv = 1'b0;
        tx_valid = 1'b1;
        tx_data  = word;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = DATA_W'($urandom);
        for (int c = 1; c <= ready_cyc() + 2; c++) begin
            if (prev_ss && !ss_n) miso_drv = sword[wire_pos(0)];
            if (!prev_sck && sck) begin
                if (ss_n !== 1'b0) win_err++;
                if (c != rise_cyc(rises)) rise_err++;
                if (rises < DW) mosi_seen[wire_pos(rises)] = mosi;
                rises++;
            end
            if (prev_sck && !sck) begin
                if (c != fall_cyc(falls)) fall_err++;
                falls++;
                last_fall = c;
                if (falls < DW) miso_drv = sword[wire_pos(falls)];
            end
            if (first_low < 0 && ss_n === 1'b0) first_low = c;
            if (!prev_ss && ss_n) begin
                high_at  = c;
                miso_drv = 1'b0;
            end
            if (rx_valid === 1'b1) begin
                rxv_cnt++;
                rxv_at = c;
                got_rx = rx_data;
            end
            if (rdy_at < 0 && tx_ready === 1'b1) rdy_at = c;
            if (ss_n === 1'b1 && mosi !== 1'b0) idle_mosi_err++;
            prev_sck = sck;
            prev_ss  = ss_n;
            @(negedge clk);
        end
        check({tag, "_ss_low_cycle"}, 32'(first_low), 32'd1);
        check({tag, "_rises"},        32'(rises), 32'(DW));
        check({tag, "_falls"},        32'(falls), 32'(DW));
        check({tag, "_rise_timing"},  32'(rise_err), 32'd0);
        check({tag, "_fall_timing"},  32'(fall_err), 32'd0);
        check({tag, "_rise_in_win"},  32'(win_err), 32'd0);
        check({tag, "_last_fall"},    32'(last_fall), 32'(fall_cyc(DW - 1)));
        check({tag, "_ss_high"},      32'(high_at), 32'(end_cyc()));
        check({tag, "_rxv_count"},    32'(rxv_cnt), 32'd1);
        check({tag, "_rxv_cycle"},    32'(rxv_at), 32'(end_cyc()));
        check({tag, "_rx_data"},      32'(got_rx), 32'(exp_rx));
        check({tag, "_rx_held"},      32'(rx_data), 32'(exp_rx));
        check({tag, "_mosi_bits"},    32'(mosi_seen), 32'(word));
        check({tag, "_ready_cycle"},  32'(rdy_at), 32'(ready_cyc()));
        check({tag, "_idle_mosi"},    32'(idle_mosi_err), 32'd0);
    endtask

    initial begin
        int viol, accepts, frames, high_run, min_gap, pulses, run, max_w, rises;
        logic prev_ss, prev_sck;
        logic [DATA_W-1:0] rx_list [2];
        logic [DATA_W-1:0] one_msb;

        // Reset and idle
        viol = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ss_n !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || rx_valid !== 1'b0 || tx_ready !== 1'b0)
                viol++;
        end
        check("reset_outputs", 32'(viol), 32'd0);
        rst_n = 1'b1;
        check("ready_before_release", 32'(tx_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(tx_ready), 32'd1);
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ss_n !== 1'b1 || sck !== 1'b0 || mosi !== 1'b0 || rx_valid !== 1'b0) viol++;
        end
        check("idle_quiet", 32'(viol), 32'd0);

        // Directed words
        run_word("a5_loop", DATA_W'(8'hA5), '0, 1'b1);
        run_word("ff_slave3c", DATA_W'(8'hFF), DATA_W'(8'h3C), 1'b0);
        run_word("01_loop", DATA_W'(8'h01), '0, 1'b1);

        // Back-to-back with tx_valid held high
        wait_ready("b2b");
        loopback = 1'b1;
        one_msb  = '0;
        one_msb[DW-1] = 1'b1;
        tx_valid = 1'b1;
        tx_data  = DATA_W'(1);
        accepts = 0; frames = 0; high_run = 0; min_gap = 1000;
        pulses = 0; run = 0; max_w = 0; prev_ss = 1'b1;
        rx_list[0] = '0; rx_list[1] = '0;
        for (int c = 0; c < 2 * ready_cyc() + 40; c++) begin
            if (tx_valid && tx_ready === 1'b1) accepts++;
            if (prev_ss && ss_n === 1'b0) begin
                if (frames > 0 && high_run < min_gap) min_gap = high_run;
                frames++;
            end
            high_run = (ss_n === 1'b1) ? high_run + 1 : 0;
            if (rx_valid === 1'b1) begin
                if (run == 0) begin
                    if (pulses < 2) rx_list[pulses] = rx_data;
                    pulses++;
                end
                run++;
                if (run > max_w) max_w = run;
            end else begin
                run = 0;
            end
            prev_ss = ss_n;
            @(negedge clk);
            if (accepts == 1) tx_data = one_msb;
            else if (accepts >= 2) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        check("b2b_accepts", 32'(accepts), 32'd2);
        check("b2b_frames", 32'(frames), 32'd2);
        check("b2b_gap_ok", 32'(min_gap >= CD + 1 && min_gap < 1000), 32'd1);
        check("b2b_rx_pulses", 32'(pulses), 32'd2);
        check("b2b_pulse_width", 32'(max_w), 32'd1);
        check("b2b_rx0", 32'(rx_list[0]), 32'(DATA_W'(1)));
        check("b2b_rx1", 32'(rx_list[1]), 32'(one_msb));

        // Reset at the 4th sck rise
        wait_ready("mid_rst");
        loopback = 1'b1;
        tx_valid = 1'b1;
        tx_data  = DATA_W'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        rises = 0; prev_sck = 1'b0;
        for (int c = 0; c < 200 && rises < 4; c++) begin
            if (!prev_sck && sck === 1'b1) rises++;
            prev_sck = sck;
            if (rises < 4) @(negedge clk);
        end
        check("mid_rst_reached", 32'(rises), 32'd4);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_sck", 32'(sck), 32'd0);
        check("mid_rst_ss_n", 32'(ss_n), 32'd1);
        check("mid_rst_mosi", 32'(mosi), 32'd0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd0);
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < ready_cyc() + 10; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || ss_n !== 1'b1) viol++;
        end
        check("mid_rst_no_rxv", 32'(viol), 32'd0);
        run_word("after_rst_5a", DATA_W'(8'h5A), '0, 1'b1);

        // Randomized words, alternating loopback and slave responses
        for (int i = 0; i < 6; i++) begin
            run_word($sformatf("rand%0d", i), DATA_W'($urandom), DATA_W'($urandom), 1'(i % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI mode-0 master. Frames one DATA_W-bit word per transaction: drives ss_n low, generates sck, shifts tx_data out on mosi and samples miso into rx_data. It is the initiator for the FPGA-side SPI slave, used to exercise and test that slave on-chip and to talk to off-board SPI peripherals. Sits between a valid/ready word interface and the four SPI pins.

Parameters:
DATA_W, 8, bits per transaction (2..32)
CLK_DIV, 4, clk cycles per SCK half-period; also lead, trail and gap length (>=4)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous active-low reset
tx_valid  input  1  word offered for transmission
tx_ready  output  1  block can accept a word this cycle
tx_data  input  DATA_W  word to send
rx_valid  output  1  one-cycle pulse: rx_data holds the word just received
rx_data  output  DATA_W  received word; held until next rx_valid
sck  output  1  SPI clock, idle low
ss_n  output  1  slave select, active low, idle high
mosi  output  1  master out
miso  input  1  master in, asynchronous to clk

Behaviour:
- Reset (rst_n low at posedge): sck=0, ss_n=1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0, state IDLE, counters 0. tx_ready=1 the first cycle after rst_n is sampled high. Reset mid-transfer aborts immediately; no rx_valid.
- miso passes through a 2-flop synchronizer before use.
- Handshake: a word is accepted when tx_valid & tx_ready at a posedge (cycle T). tx_ready is 1 only in IDLE. tx_data is captured at T; later tx_data changes are ignored.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> GAP -> IDLE.
- LEAD: from T+1, ss_n=0, mosi=first bit (MSB). CLK_DIV cycles, then SHIFT.
- SHIFT: sck toggles every CLK_DIV cycles, starting with a rise at T+1+CLK_DIV; exactly DATA_W rising and DATA_W falling edges. mosi changes only in the cycle sck falls, presenting the next bit. The synchronized miso is sampled in the cycle sck falls (end of the high phase) and shifted into the receive register. After the DATA_W-th fall, go to TRAIL with sck=0.
- TRAIL: CLK_DIV cycles with ss_n=0, then ss_n=1. rx_valid pulses and rx_data updates in that same cycle. Go to GAP.
- GAP: CLK_DIV cycles with ss_n=1, then IDLE with tx_ready=1. Back-to-back words always get a new ss_n frame.
- Timing (DATA_W=8, CLK_DIV=4, accept at cycle 0): ss_n low at 1, sck rises at 5,13,...,61, last fall at 65, ss_n high and rx_valid at 69, tx_ready at 73.
- mosi=0 whenever ss_n=1.
- The divider counter is CLK_DIV-width and wraps to 0 at CLK_DIV-1. The bit counter counts 0..DATA_W-1 with no overflow.
- tx_valid while busy is ignored, not queued.

Optional Feature:
SPI_MASTER_LSB_FIRST_EN
- Defined: mosi sends bit 0 first. Received bits shift in from the MSB side, so the first bit on the wire lands in rx_data[0].
- Undefined (default): MSB first on both mosi and rx_data. First wire bit lands in rx_data[DATA_W-1].
- Timing is identical in both builds.

Decomposition:
- Package spi_pkg: state enum (IDLE, LEAD, SHIFT, TRAIL, GAP); SPI mode constants (CPOL=0, CPHA=0); default DATA_W and CLK_DIV localparams shared with the slave bench.
- One sub-module, spi_clk_div: half-period tick generator (counter, enable, clear). Emits a one-cycle tick every CLK_DIV cycles while enabled.
- Shift registers and FSM stay in spi_master.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high -> ss_n=1, sck=0, mosi=0 throughout; tx_ready=1 one cycle after release; rx_valid never asserts.
- Single word with loopback miso=mosi, tx_data=8'hA5, CLK_DIV=4 -> edges at cycles 5..65 as above; mosi sequence 1,0,1,0,0,1,0,1; rx_valid at 69 with rx_data=8'hA5; tx_ready at 73.
- Slave model returns 8'h3C while master sends 8'hFF -> rx_data=8'h3C; exactly 8 sck rises inside the ss_n low window.
- Back-to-back: tx_valid held high with 8'h01 then 8'h80 -> two separate ss_n frames, ss_n high >= CLK_DIV+1 cycles between them; rx_valid pulses twice, each exactly 1 cycle.
- Reset mid-transfer: rst_n low at the 4th sck rise -> next cycle sck=0, ss_n=1, mosi=0, no rx_valid; a subsequent word (8'h5A) completes correctly.
- Build with SPI_MASTER_LSB_FIRST_EN, tx_data=8'h01, loopback -> first mosi bit 1 then seven 0s; rx_data=8'h01.
